// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder.
//  - Phase codes, written as {A, B} and listed in forward order: 00, 01, 11, 10.
//  - Direction encodings.
//  - Default position width.
//  - The move classification type and the decode table that fills it.
package quad_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        MOVE_NONE    = 2'd0,
        MOVE_FWD     = 2'd1,
        MOVE_REV     = 2'd2,
        MOVE_ILLEGAL = 2'd3
    } move_t;

    // Classifies one sample-to-sample phase change.
    // Both bits flipping means a phase was missed, and the direction cannot be known.
    function automatic move_t decode_move(input logic [1:0] prev, input logic [1:0] cur);
        move_t m;
        m = MOVE_NONE;
        case ({prev, cur})
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: m = MOVE_FWD;
            {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: m = MOVE_REV;
            {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: m = MOVE_ILLEGAL;
            default: m = MOVE_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Bus bundle for the quadrature decoder.
//  master : drives qa, qb, load, data and clear_err; observes step, dir, pos and err.
//  slave  : the decoder side of the bundle.
interface quadrature_decoder_if #(
    parameter int WIDTH = quad_pkg::WIDTH_DEF
);
    logic             qa;
    logic             qb;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             clear_err;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] pos;
    logic             err;

    modport master (
        output qa, qb, load, data, clear_err,
        input  step, dir, pos, err
    );

    modport slave (
        input  qa, qb, load, data, clear_err,
        output step, dir, pos, err
    );
endinterface

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
// Ports:
//  clk   : destination clock
//  rst_n : asynchronous active-low reset; clears every stage to 0
//  d     : asynchronous input
//  q     : synchronised output, SYNC_STAGES clk edges behind d
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder.
//  - Turns an asynchronous A/B phase pair into registered step/dir events.
//  - Keeps a loadable position count that wraps modulo 2^WIDTH.
//  - Raises a sticky err when both phases change between two samples.
// Ports:
//  clk   : system clock
//  rst_n : asynchronous active-low reset
//  bus   : quadrature_decoder_if.slave
//          inputs  : qa, qb, load, data, clear_err
//          outputs : step, dir, pos, err (all registered)
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    quadrature_decoder_if.slave bus
);

    // Decoding stays off until the synchronisers and prev hold real samples.
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);

    logic             qa_s;
    logic             qb_s;
    logic [1:0]       cur;
    logic [1:0]       prev;
    logic [PW-1:0]    prime_cnt;
    logic             primed;
    move_t            mv;

    logic             step_r;
    logic             dir_r;
    logic [WIDTH-1:0] pos_r;
    logic             err_r;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.qa),
        .q     (qa_s)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.qb),
        .q     (qb_s)
    );

    assign cur    = {qa_s, qb_s};
    assign primed = (prime_cnt == PW'(PRIME_CYCLES));
    assign mv     = decode_move(prev, cur);

    // Decode stage: compare prev -> cur, update the event and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= PH_00;
            prime_cnt <= '0;
            step_r    <= 1'b0;
            dir_r     <= DIR_REV;
            pos_r     <= '0;
            err_r     <= 1'b0;
        end else begin
            prev   <= cur;
            step_r <= 1'b0;

            if (!primed) begin
                prime_cnt <= prime_cnt + PW'(1);
            end

            if (primed && (mv == MOVE_FWD)) begin
                step_r <= 1'b1;
                dir_r  <= DIR_FWD;
            end else if (primed && (mv == MOVE_REV)) begin
                step_r <= 1'b1;
                dir_r  <= DIR_REV;
            end

            // A load overrides the step for pos, but step/dir above still report it.
            if (bus.load) begin
                pos_r <= bus.data;
            end else if (primed && (mv == MOVE_FWD)) begin
                pos_r <= pos_r + WIDTH'(1);
            end else if (primed && (mv == MOVE_REV)) begin
                pos_r <= pos_r - WIDTH'(1);
            end

            // A new illegal jump wins over a simultaneous clear.
            if (primed && (mv == MOVE_ILLEGAL)) begin
                err_r <= 1'b1;
            end else if (bus.clear_err) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.step = step_r;
    assign bus.dir  = dir_r;
    assign bus.pos  = pos_r;
    assign bus.err  = err_r;

endmodule
